// File: rtl/hazard_stall_controller_pkg.sv
// Shared pipeline definitions: opcodes, controller state encoding and the
// per-stage control bundle used by the hazard/stall sequencer.
package pipe_pkg;

    localparam int DEF_REG_INDEX_BIT_WIDTH = 4;

    localparam logic [3:0] OP_NOP    = 4'b0000;
    localparam logic [3:0] OP_BRANCH = 4'b0010;
    localparam logic [3:0] OP_SW     = 4'b0011;
    localparam logic [3:0] OP_LW     = 4'b0100;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    // Per-stage pipeline controls, in PC -> EX/MEM order.
    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_bubble;
        logic ex_mem_stall;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE  = 5'b00000;
    localparam ctrl_t CTRL_LU    = 5'b11010;  // hold front end, bubble into EX
    localparam ctrl_t CTRL_FRZ   = 5'b11001;  // freeze everything up to EX/MEM
    localparam ctrl_t CTRL_FLUSH = 5'b00110;  // squash wrong-path fetch

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Bundle of hazard inputs from ID/EX/MEM and the per-stage controls back.
interface hazard_stall_controller_if #(
    parameter int RIW       = 4,
    parameter int CNT_WIDTH = 16
);
    logic             id_valid;
    logic [RIW-1:0]   id_rs1;
    logic [RIW-1:0]   id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic             ex_valid;
    logic [3:0]       ex_opcode;
    logic [RIW-1:0]   ex_rd;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ready;

    logic             pc_stall;
    logic             if_id_stall;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             ex_mem_stall;
    logic             mem_timeout_err;
    logic [CNT_WIDTH-1:0] stall_cycles;

    // Pipeline side: reports hazards, consumes controls.
    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               ex_valid, ex_opcode, ex_rd, ex_branch_taken, mem_req, mem_ready,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall,
               mem_timeout_err, stall_cycles
    );

    // Controller side.
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               ex_valid, ex_opcode, ex_rd, ex_branch_taken, mem_req, mem_ready,
        output pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall,
               mem_timeout_err, stall_cycles
    );

endinterface

// File: rtl/hazard_stall_controller_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_inc,
    input  logic                 i_clr,
    output logic [CNT_WIDTH-1:0] o_count
);
    logic [CNT_WIDTH-1:0] r_count;

    // Count increments, clear and reset win, hold once saturated.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {CNT_WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard sequencer: load-use bubbles, data-memory freeze with
// timeout, taken-branch squash. Controls are Mealy on state and inputs.
module hazard_stall_controller
    import pipe_pkg::*;
#(
    parameter int REG_INDEX_BIT_WIDTH = DEF_REG_INDEX_BIT_WIDTH,
    parameter int LOAD_USE_PENALTY    = 1,
    parameter int MEM_TIMEOUT         = 255,
    parameter int CNT_WIDTH           = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    hazard_stall_controller_if.slave  bus
);
    localparam int               TO_W      = $clog2(MEM_TIMEOUT + 1);
    localparam logic [2:0]       LU_RELOAD = 3'(LOAD_USE_PENALTY - 1);
    localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'(MEM_TIMEOUT);

    logic [REG_INDEX_BIT_WIDTH-1:0] w_rs1, w_rs2, w_rd;
    state_t          r_state, w_state_nxt;
    logic [2:0]      r_lu_cnt, w_lu_cnt_nxt;
    logic [TO_W-1:0] r_to_cnt, w_to_cnt_nxt;
    logic            r_br_pending, w_br_pending_nxt;
    logic            r_timeout_err, w_timeout_err_nxt;
    logic            w_lu_hit, w_mem_hold, w_br_taken, w_release;
    ctrl_t           w_ctrl, w_ctrl_out;
    logic [CNT_WIDTH-1:0] w_stall_cycles;

    assign w_rs1 = bus.id_rs1;
    assign w_rs2 = bus.id_rs2;
    assign w_rd  = bus.ex_rd;

    assign w_lu_hit   = bus.ex_valid && (bus.ex_opcode == OP_LW) && bus.id_valid &&
                        ((bus.id_rs1_used && (w_rs1 == w_rd)) ||
                         (bus.id_rs2_used && (w_rs2 == w_rd)));
    assign w_mem_hold = bus.mem_req && !bus.mem_ready;
    assign w_br_taken = bus.ex_valid && bus.ex_branch_taken;

    // State and hazard bookkeeping registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_lu_cnt      <= '0;
            r_to_cnt      <= '0;
            r_br_pending  <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_lu_cnt      <= w_lu_cnt_nxt;
            r_to_cnt      <= w_to_cnt_nxt;
            r_br_pending  <= w_br_pending_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    // Next-state and control decode; memory hold outranks branch outranks load-use.
    always_comb begin
        w_state_nxt       = r_state;
        w_lu_cnt_nxt      = r_lu_cnt;
        w_to_cnt_nxt      = r_to_cnt;
        w_br_pending_nxt  = r_br_pending;
        w_timeout_err_nxt = r_timeout_err;
        w_release         = 1'b0;
        w_ctrl            = CTRL_NONE;
        case (r_state)
            ST_RUN: begin
                if (w_mem_hold) begin
                    w_ctrl           = CTRL_FRZ;
                    w_br_pending_nxt = w_br_taken;  // redirect deferred until memory returns
                    w_to_cnt_nxt     = TO_W'(1);
                    w_state_nxt      = ST_MEM_WAIT;
                end else if (w_br_taken) begin
                    w_ctrl = CTRL_FLUSH;            // ID instruction is wrong-path anyway
                end else if (w_lu_hit) begin
                    w_ctrl = CTRL_LU;
                    if (LOAD_USE_PENALTY > 1) begin
                        w_lu_cnt_nxt = LU_RELOAD;
                        w_state_nxt  = ST_LU_STALL;
                    end
                end
            end
            ST_LU_STALL: begin
                if (w_mem_hold) begin
                    w_ctrl           = CTRL_FRZ;
                    w_lu_cnt_nxt     = '0;
                    w_br_pending_nxt = 1'b0;        // EX holds a bubble here
                    w_to_cnt_nxt     = TO_W'(1);
                    w_state_nxt      = ST_MEM_WAIT;
                end else begin
                    w_ctrl = CTRL_LU;
                    if (r_lu_cnt <= 3'd1) begin
                        w_lu_cnt_nxt = '0;
                        w_state_nxt  = ST_RUN;
                    end else begin
                        w_lu_cnt_nxt = r_lu_cnt - 3'd1;
                    end
                end
            end
            ST_MEM_WAIT: begin
                // Dropping mem_req also ends the wait, same as mem_ready.
                if (!w_mem_hold) begin
                    w_release = 1'b1;
                end else if (r_to_cnt == TO_LIMIT) begin
                    w_release         = 1'b1;
                    w_timeout_err_nxt = 1'b1;
                end else begin
                    w_ctrl       = CTRL_FRZ;
                    w_to_cnt_nxt = r_to_cnt + 1'b1;
                end
                if (w_release) begin
                    if (r_br_pending) begin
                        w_ctrl = CTRL_FLUSH;
                    end
                    w_br_pending_nxt = 1'b0;
                    w_to_cnt_nxt     = '0;
                    w_state_nxt      = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Controls are forced quiet while reset is held, independent of inputs.
    assign w_ctrl_out = rst_n ? w_ctrl : CTRL_NONE;

    assign bus.pc_stall        = w_ctrl_out.pc_stall;
    assign bus.if_id_stall     = w_ctrl_out.if_id_stall;
    assign bus.if_id_flush     = w_ctrl_out.if_id_flush;
    assign bus.id_ex_bubble    = w_ctrl_out.id_ex_bubble;
    assign bus.ex_mem_stall    = w_ctrl_out.ex_mem_stall;
    assign bus.mem_timeout_err = r_timeout_err && rst_n;
    assign bus.stall_cycles    = w_stall_cycles;

    sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_ctrl_out.pc_stall),
        .i_clr   (1'b0),
        .o_count (w_stall_cycles)
    );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench: DUT A (penalty 1, timeout 255, 16-bit count) and DUT B
// (penalty 3, timeout 4, 4-bit count) see identical stimulus.
module tb_hazard_stall_controller;
    import pipe_pkg::*;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    hazard_stall_controller_if #(.RIW(4), .CNT_WIDTH(16)) ia ();
    hazard_stall_controller_if #(.RIW(4), .CNT_WIDTH(4))  ib ();

    assign ib.id_valid        = ia.id_valid;
    assign ib.id_rs1          = ia.id_rs1;
    assign ib.id_rs2          = ia.id_rs2;
    assign ib.id_rs1_used     = ia.id_rs1_used;
    assign ib.id_rs2_used     = ia.id_rs2_used;
    assign ib.ex_valid        = ia.ex_valid;
    assign ib.ex_opcode       = ia.ex_opcode;
    assign ib.ex_rd           = ia.ex_rd;
    assign ib.ex_branch_taken = ia.ex_branch_taken;
    assign ib.mem_req         = ia.mem_req;
    assign ib.mem_ready       = ia.mem_ready;

    hazard_stall_controller #(
        .REG_INDEX_BIT_WIDTH (4), .LOAD_USE_PENALTY (1), .MEM_TIMEOUT (255), .CNT_WIDTH (16)
    ) u_dut_a (.clk (clk), .rst_n (rst_n), .bus (ia.slave));

    hazard_stall_controller #(
        .REG_INDEX_BIT_WIDTH (4), .LOAD_USE_PENALTY (3), .MEM_TIMEOUT (4), .CNT_WIDTH (4)
    ) u_dut_b (.clk (clk), .rst_n (rst_n), .bus (ib.slave));

    // {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall, mem_timeout_err}
    wire [5:0] oa = {ia.pc_stall, ia.if_id_stall, ia.if_id_flush, ia.id_ex_bubble, ia.ex_mem_stall, ia.mem_timeout_err};
    wire [5:0] ob = {ib.pc_stall, ib.if_id_stall, ib.if_id_flush, ib.id_ex_bubble, ib.ex_mem_stall, ib.mem_timeout_err};

    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] LU   = 6'b110100;
    localparam logic [5:0] FRZ  = 6'b110010;
    localparam logic [5:0] FLS  = 6'b001100;
    localparam logic [5:0] ERR  = 6'b000001;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ia.id_valid = 0; ia.id_rs1 = 0; ia.id_rs2 = 0; ia.id_rs1_used = 0; ia.id_rs2_used = 0;
        ia.ex_valid = 0; ia.ex_opcode = OP_NOP; ia.ex_rd = 0; ia.ex_branch_taken = 0;
        ia.mem_req = 0; ia.mem_ready = 0;
    endtask

    task automatic lu_hazard();
        ia.ex_valid = 1; ia.ex_opcode = OP_LW; ia.ex_rd = 4'd3;
        ia.id_valid = 1; ia.id_rs1 = 4'd3; ia.id_rs1_used = 1; ia.id_rs2 = 4'd7; ia.id_rs2_used = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        lu_hazard(); ia.ex_branch_taken = 1; ia.mem_req = 1;
        tick(); tick(); #2;
        n_total++; if (oa !== NONE) $display("FAIL reset_hold_a: got %b exp %b", oa, NONE); else n_pass++;
        n_total++; if (ob !== NONE) $display("FAIL reset_hold_b: got %b exp %b", ob, NONE); else n_pass++;
        n_total++; if (ia.stall_cycles !== 16'd0) $display("FAIL reset_cnt_a: got %0d exp 0", ia.stall_cycles); else n_pass++;
        n_total++; if (ib.stall_cycles !== 4'd0) $display("FAIL reset_cnt_b: got %0d exp 0", ib.stall_cycles); else n_pass++;
        idle(); rst_n = 1; #2;
        n_total++; if (oa !== NONE) $display("FAIL reset_idle_a: got %b exp %b", oa, NONE); else n_pass++;
        n_total++; if (ob !== NONE) $display("FAIL reset_idle_b: got %b exp %b", ob, NONE); else n_pass++;
        tick();
    endtask

    // One hazard cycle: A stalls once, B stalls for three cycles.
    task automatic test_lu_penalty();
        lu_hazard(); #2;
        n_total++; if (oa !== LU) $display("FAIL lu_c0_a: got %b exp %b", oa, LU); else n_pass++;
        n_total++; if (ob !== LU) $display("FAIL lu_c0_b: got %b exp %b", ob, LU); else n_pass++;
        tick(); idle(); #2;
        for (int c = 1; c < 3; c++) begin
            n_total++; if (oa !== NONE) $display("FAIL lu_c%0d_a: got %b exp %b", c, oa, NONE); else n_pass++;
            n_total++; if (ob !== LU) $display("FAIL lu_c%0d_b: got %b exp %b", c, ob, LU); else n_pass++;
            tick(); #2;
        end
        n_total++; if (ob !== NONE) $display("FAIL lu_c3_b: got %b exp %b", ob, NONE); else n_pass++;
        n_total++; if (ia.stall_cycles !== 16'd1) $display("FAIL lu_cnt_a: got %0d exp 1", ia.stall_cycles); else n_pass++;
        n_total++; if (ib.stall_cycles !== 4'd3) $display("FAIL lu_cnt_b: got %0d exp 3", ib.stall_cycles); else n_pass++;
        tick();
    endtask

    task automatic test_lu_operands();
        lu_hazard(); ia.id_rs1_used = 0; ia.id_rs2 = 4'd5; #2;
        n_total++; if (oa !== NONE) $display("FAIL rs1_unused_a: got %b exp %b", oa, NONE); else n_pass++;
        n_total++; if (ob !== NONE) $display("FAIL rs1_unused_b: got %b exp %b", ob, NONE); else n_pass++;
        tick();
        lu_hazard(); ia.ex_opcode = OP_SW; #2;
        n_total++; if (oa !== NONE) $display("FAIL not_load_a: got %b exp %b", oa, NONE); else n_pass++;
        tick();
        lu_hazard(); ia.id_rs1_used = 0; ia.id_rs2 = 4'd3; #2;
        n_total++; if (oa !== LU) $display("FAIL rs2_hit_a: got %b exp %b", oa, LU); else n_pass++;
        n_total++; if (ob !== LU) $display("FAIL rs2_hit_b: got %b exp %b", ob, LU); else n_pass++;
        tick(); idle(); tick(); tick(); #2;
        n_total++; if (ia.stall_cycles !== 16'd2) $display("FAIL rs_cnt_a: got %0d exp 2", ia.stall_cycles); else n_pass++;
        n_total++; if (ib.stall_cycles !== 4'd6) $display("FAIL rs_cnt_b: got %0d exp 6", ib.stall_cycles); else n_pass++;
    endtask

    task automatic test_mem_wait();
        ia.mem_req = 1; ia.mem_ready = 0;
        for (int c = 0; c < 4; c++) begin
            #2;
            n_total++; if (oa !== FRZ) $display("FAIL mem_c%0d_a: got %b exp %b", c, oa, FRZ); else n_pass++;
            n_total++; if (ob !== FRZ) $display("FAIL mem_c%0d_b: got %b exp %b", c, ob, FRZ); else n_pass++;
            tick();
        end
        ia.mem_ready = 1; #2;
        n_total++; if (oa !== NONE) $display("FAIL mem_rel_a: got %b exp %b", oa, NONE); else n_pass++;
        n_total++; if (ob !== NONE) $display("FAIL mem_rel_b: got %b exp %b", ob, NONE); else n_pass++;
        tick(); idle(); #2;
        n_total++; if (ob !== NONE) $display("FAIL mem_after_b: got %b exp %b", ob, NONE); else n_pass++;
        n_total++; if (ia.stall_cycles !== 16'd6) $display("FAIL mem_cnt_a: got %0d exp 6", ia.stall_cycles); else n_pass++;
        n_total++; if (ib.stall_cycles !== 4'd10) $display("FAIL mem_cnt_b: got %0d exp 10", ib.stall_cycles); else n_pass++;
        tick();
    endtask

    task automatic test_branch_mem();
        ia.ex_valid = 1; ia.ex_opcode = OP_BRANCH; ia.ex_branch_taken = 1; ia.mem_req = 1;
        for (int c = 0; c < 2; c++) begin
            #2;
            n_total++; if (oa !== FRZ) $display("FAIL brmem_c%0d_a: got %b exp %b", c, oa, FRZ); else n_pass++;
            tick();
        end
        ia.ex_branch_taken = 0; ia.mem_ready = 1; #2;
        n_total++; if (oa !== FLS) $display("FAIL brmem_rel_a: got %b exp %b", oa, FLS); else n_pass++;
        n_total++; if (ob !== FLS) $display("FAIL brmem_rel_b: got %b exp %b", ob, FLS); else n_pass++;
        tick(); idle(); #2;
        n_total++; if (oa !== NONE) $display("FAIL brmem_strobe_a: got %b exp %b", oa, NONE); else n_pass++;
        tick();
    endtask

    task automatic test_branch_lu();
        lu_hazard(); ia.ex_branch_taken = 1; #2;
        n_total++; if (oa !== FLS) $display("FAIL brlu_a: got %b exp %b", oa, FLS); else n_pass++;
        n_total++; if (ob !== FLS) $display("FAIL brlu_b: got %b exp %b", ob, FLS); else n_pass++;
        tick(); idle(); #2;
        n_total++; if (ob !== NONE) $display("FAIL brlu_after_b: got %b exp %b", ob, NONE); else n_pass++;
        tick();
    endtask

    // B releases on its own after 4 frozen cycles; A waits until mem_req drops.
    task automatic test_timeout();
        ia.mem_req = 1;
        for (int c = 0; c < 4; c++) begin
            #2;
            n_total++; if (ob !== FRZ) $display("FAIL to_c%0d_b: got %b exp %b", c, ob, FRZ); else n_pass++;
            tick();
        end
        #2;
        n_total++; if (ob !== NONE) $display("FAIL to_rel_b: got %b exp %b", ob, NONE); else n_pass++;
        n_total++; if (oa !== FRZ) $display("FAIL to_wait_a: got %b exp %b", oa, FRZ); else n_pass++;
        tick(); ia.mem_req = 0; #2;
        n_total++; if (ob !== ERR) $display("FAIL to_err_b: got %b exp %b", ob, ERR); else n_pass++;
        n_total++; if (oa !== NONE) $display("FAIL to_rel_a: got %b exp %b", oa, NONE); else n_pass++;
        n_total++; if (ia.stall_cycles !== 16'd13) $display("FAIL to_cnt_a: got %0d exp 13", ia.stall_cycles); else n_pass++;
        n_total++; if (ib.stall_cycles !== 4'hF) $display("FAIL to_cnt_b_sat: got %0d exp 15", ib.stall_cycles); else n_pass++;
        tick();
    endtask

    // Held hazard: B takes back-to-back full penalties; its counter stays saturated.
    task automatic test_back_to_back();
        lu_hazard();
        for (int c = 0; c < 6; c++) begin
            #2;
            n_total++; if (ob !== (LU | ERR)) $display("FAIL b2b_c%0d_b: got %b exp %b", c, ob, LU | ERR); else n_pass++;
            tick();
        end
        idle(); #2;
        n_total++; if (ob !== ERR) $display("FAIL b2b_end_b: got %b exp %b", ob, ERR); else n_pass++;
        n_total++; if (ib.stall_cycles !== 4'hF) $display("FAIL sat_hold_b: got %0d exp 15", ib.stall_cycles); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_stall();
        lu_hazard(); tick(); idle(); rst_n = 0; #2;
        n_total++; if (ob !== NONE) $display("FAIL rst_lu_b: got %b exp %b", ob, NONE); else n_pass++;
        tick(); rst_n = 1; #2;
        n_total++; if (ob !== NONE) $display("FAIL rst_lu_after_b: got %b exp %b", ob, NONE); else n_pass++;
        n_total++; if (ib.stall_cycles !== 4'd0) $display("FAIL rst_lu_cnt_b: got %0d exp 0", ib.stall_cycles); else n_pass++;
        tick();
        ia.mem_req = 1; tick(); #2;
        n_total++; if (oa !== FRZ) $display("FAIL rst_mem_pre_a: got %b exp %b", oa, FRZ); else n_pass++;
        rst_n = 0; #1;
        n_total++; if (oa !== NONE) $display("FAIL rst_mem_a: got %b exp %b", oa, NONE); else n_pass++;
        tick(); rst_n = 1; ia.mem_req = 0; #2;
        n_total++; if (oa !== NONE) $display("FAIL rst_mem_after_a: got %b exp %b", oa, NONE); else n_pass++;
        n_total++; if (ia.stall_cycles !== 16'd0) $display("FAIL rst_mem_cnt_a: got %0d exp 0", ia.stall_cycles); else n_pass++;
        tick();
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        rst_n = 0; idle();
        tick();
        test_reset();
        test_lu_penalty();
        test_lu_operands();
        test_mem_wait();
        test_branch_mem();
        test_branch_lu();
        test_timeout();
        test_back_to_back();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
